i2c_slave_responder: RTL and testbench
======================================

Name: i2c_slave_responder

Overview:
- Target (slave) end of the I2C link driven by the team's I2C master and its SCL divider (100 kHz SCL from the 50 MHz ref_clk).
- Oversamples SCL/SDA on ref_clk, detects START/STOP, matches a 7-bit address, and ACKs.
- Exposes a byte-wide register port: first written byte = register pointer, following bytes write/read consecutive registers.
- Sits between the board I2C pins (open-drain pads outside this block) and a local 256x8 register file.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this target responds to.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (minimum 2).

Ports:
- ref_clk, input, 1, 50 MHz system clock; all logic on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- scl_in, input, 1, raw SCL pad value (asynchronous).
- sda_in, input, 1, raw SDA pad value (asynchronous).
- sda_oe, output, 1, 1 = pull SDA low, 0 = release (high-Z).
- reg_addr, output, 8, current register pointer.
- reg_wdata, output, 8, write data; valid while reg_we=1.
- reg_we, output, 1, one-ref_clk write strobe.
- reg_re, output, 1, one-ref_clk read strobe.
- reg_rdata, input, 8, read data; must be valid on the cycle after reg_re (1-cycle registered read).
- busy, output, 1, high from START until STOP.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - sda_oe=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, busy=0.
  - State=IDLE; synchronizers preset to 1 (bus idle).
- Input conditioning:
  - scl_s/sda_s = SYNC_STAGES-flop synchronized copies, plus one extra register each for edge detection.
  - scl_rise / scl_fall = single-cycle pulses.
- Bus conditions:
  - START = sda_s falls while scl_s=1; STOP = sda_s rises while scl_s=1.
  - Both are evaluated in every state and take priority over the bit logic.
  - START (incl. repeated START): state=ADDR, bit count=0, sda_oe=0, busy=1. Pointer is kept.
  - STOP: state=IDLE, sda_oe=0, busy=0.
- Data sampling:
  - Shift in sda_s MSB first on scl_rise.
  - Drive sda_oe only on scl_fall, so SDA is stable while SCL is high. Hold time = sync latency, about 3 ref_clk cycles.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - After the 8th scl_rise: if addr==SLAVE_ADDR, go to ADDR_ACK.
    - Otherwise go to IGNORE (sda_oe stays 0 until START/STOP).
  - ADDR_ACK:
    - On the next scl_fall: sda_oe=1.
    - On the following scl_fall: if W, sda_oe=0, go to WR_BYTE with first_byte=1.
    - If R: pulse reg_re; the next ref_clk cycle loads reg_rdata into the shift register and drives sda_oe=~bit7; go to RD_BYTE.
  - WR_BYTE: shift 8 bits, then go to WR_ACK.
  - WR_ACK:
    - ACK on scl_fall, release on the following scl_fall.
    - If first_byte: reg_addr <= byte, first_byte=0.
    - Otherwise: reg_wdata <= byte, reg_we pulses one cycle at the ACK-driving scl_fall, reg_addr increments on the cycle after reg_we.
    - Then return to WR_BYTE.
  - RD_BYTE:
    - Shift out on each scl_fall (sda_oe = ~bit).
    - After the 8th bit's scl_fall: sda_oe=0, go to RD_ACK.
  - RD_ACK:
    - Sample master ACK on scl_rise.
    - ACK (sda=0): reg_addr+1; on the next scl_fall pulse reg_re, load, drive bit7; go to RD_BYTE.
    - NACK: go to IGNORE with sda_oe=0.
  - IGNORE: do nothing until START/STOP.
- Pointer arithmetic: reg_addr is an 8-bit wrap; 8'hFF+1 = 8'h00.
- reg_we and reg_re are never asserted in the same cycle.
- Reset mid-transfer: releases SDA immediately (asynchronous); the block then waits for a fresh START.
- Out-of-spec SCL stretching is not performed; the block never drives SCL.

Decomposition:
- Shared package i2c_pkg:
  - State enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE).
  - Constants I2C_RW_READ=1, I2C_ACK=0.
- One sub-module: i2c_bus_sync. It holds the SYNC_STAGES synchronizer and edge detectors, and outputs scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det. The master side reuses it.

Test Plan:
- Reset: hold reset_n=0 mid-byte with SDA driven -> sda_oe=0, busy=0 within the same cycle, no reg_we/reg_re pulses.
- Write: START, 0x84 (addr 0x42 W), 0x10, 0xAB, 0xCD, STOP. Required response:
  - ACK on all 4 bytes.
  - reg_we pulses twice: (0x10, 0xAB), then (0x11, 0xCD).
  - reg_addr=0x12 at end; busy falls at STOP.
- Read: START, 0x84, 0x20, repeated START, 0x85, master ACK, master NACK, STOP, with register model 0x20=0x5A, 0x21=0xC3. Required response:
  - Bytes 0x5A then 0xC3 seen on SDA.
  - reg_re pulses exactly twice; sda_oe=0 after NACK.
- Address mismatch: START, 0x86 (addr 0x43), 0x55, STOP -> sda_oe never 1, no strobes, state IDLE after STOP.
- Wrap and STOP abort:
  - Pointer 0xFF, write 0x11, 0x22 -> writes land at 0xFF then 0x00.
  - Then STOP after 4 bits of a further byte -> no reg_we, state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Pin-level and register-port signals of the I2C target, grouped for port lists.
interface i2c_slave_responder_if;

  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge pulses and START/STOP detection (SYNC_STAGES >= 2).
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ref_clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  // Preset to 1 so a reset never looks like a bus transition.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, ACK generation and byte-wide register access
// through a pointer that auto-increments after every data byte.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input logic                  ref_clk,
  input logic                  reset_n,
  i2c_slave_responder_if.slave bus
);

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  i2c_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       first_byte;
  logic       ack_phase;
  logic       load_now;
  logic       sda_oe_r;
  logic [7:0] reg_addr_r;
  logic [7:0] reg_wdata_r;
  logic       reg_we_r;
  logic       reg_re_r;
  logic       busy_r;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .ref_clk   (ref_clk),
    .reset_n   (reset_n),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // START/STOP override the bit-level state machine in every state.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      rw          <= 1'b0;
      first_byte  <= 1'b0;
      ack_phase   <= 1'b0;
      load_now    <= 1'b0;
      sda_oe_r    <= 1'b0;
      reg_addr_r  <= '0;
      reg_wdata_r <= '0;
      reg_we_r    <= 1'b0;
      reg_re_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      reg_we_r <= 1'b0;
      reg_re_r <= 1'b0;
      load_now <= reg_re_r;
      if (reg_we_r)
        reg_addr_r <= reg_addr_r + 8'd1;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        unique case (state)
          ADDR, WR_BYTE: if (scl_rise) begin
            shift   <= {shift[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_phase <= 1'b0;
              if (state == WR_BYTE) begin
                state <= WR_ACK;
              end else begin
                rw    <= sda_s;
                state <= (shift[6:0] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase <= 1'b1;
              sda_oe_r  <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (rw == I2C_RW_READ) begin
                reg_re_r <= 1'b1;
                state    <= RD_BYTE;
              end else begin
                sda_oe_r   <= 1'b0;
                first_byte <= 1'b1;
                state      <= WR_BYTE;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase <= 1'b1;
              sda_oe_r  <= 1'b1;
              if (first_byte) begin
                reg_addr_r <= shift;
                first_byte <= 1'b0;
              end else begin
                reg_wdata_r <= shift;
                reg_we_r    <= 1'b1;
              end
            end else begin
              ack_phase <= 1'b0;
              sda_oe_r  <= 1'b0;
              bit_cnt   <= '0;
              state     <= WR_BYTE;
            end
          end
          // Read data arrives two cycles after the strobe; launch it only while SCL is low.
          RD_BYTE: begin
            if (load_now && !scl_s) begin
              shift    <= bus.reg_rdata;
              sda_oe_r <= ~bus.reg_rdata[7];
            end else if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_oe_r  <= 1'b0;
                ack_phase <= 1'b0;
                state     <= RD_ACK;
              end else begin
                shift    <= {shift[6:0], 1'b0};
                sda_oe_r <= ~shift[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_ACK) begin
                reg_addr_r <= reg_addr_r + 8'd1;
                ack_phase  <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              reg_re_r  <= 1'b1;
              state     <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_r;
  assign bus.reg_addr  = reg_addr_r;
  assign bus.reg_wdata = reg_wdata_r;
  assign bus.reg_we    = reg_we_r;
  assign bus.reg_re    = reg_re_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, 256x8 register model
// and a strobe scoreboard fed with expected writes/reads.
module tb_i2c_slave_responder;

  localparam int Q = 20;
  localparam int H = 40;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       ref_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl     = 1'b1;
  logic       sda_m   = 1'b1;
  logic [7:0] rdata   = 8'h00;
  logic [7:0] mem [256];
  logic       oe_seen = 1'b0;
  int         checks  = 0;
  int         fails   = 0;
  wr_t        exp_we [$];
  logic [7:0] exp_re [$];
  wr_t        mon_e;
  logic [7:0] mon_a;
  logic       ack;
  logic [7:0] rx;

  i2c_slave_responder_if intf();

  i2c_slave_responder dut (
    .ref_clk (ref_clk),
    .reset_n (reset_n),
    .bus     (intf)
  );

  always #10 ref_clk = ~ref_clk;

  assign intf.scl_in    = scl;
  assign intf.sda_in    = sda_m & ~intf.sda_oe;
  assign intf.reg_rdata = rdata;

  // Registered-read register file: data valid the cycle after reg_re.
  always @(posedge ref_clk) begin
    if (intf.reg_re) rdata <= mem[intf.reg_addr];
    if (intf.reg_we) mem[intf.reg_addr] <= intf.reg_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Strobe scoreboard: every reg_we/reg_re must match the next queued expectation.
  always @(negedge ref_clk) begin
    if (intf.sda_oe) oe_seen = 1'b1;
    if (intf.reg_we) begin
      if (exp_we.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_we: got addr %0h data %0h, required no write", intf.reg_addr, intf.reg_wdata);
      end else begin
        mon_e = exp_we.pop_front();
        checkOutput("we_addr", 32'(intf.reg_addr), 32'(mon_e.addr));
        checkOutput("we_data", 32'(intf.reg_wdata), 32'(mon_e.data));
        checkOutput("we_re_exclusive", 32'(intf.reg_re), 32'd0);
      end
    end
    if (intf.reg_re) begin
      if (exp_re.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_re: got addr %0h, required no read", intf.reg_addr);
      end else begin
        mon_a = exp_re.pop_front();
        checkOutput("re_addr", 32'(intf.reg_addr), 32'(mon_a));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge ref_clk);
  endtask

  task automatic applyStimulus(input logic scl_v, input logic sda_v, input int cycles);
    scl   = scl_v;
    sda_m = sda_v;
    waitCycles(cycles);
  endtask

  task automatic i2cStart();
    applyStimulus(scl, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, H);
  endtask

  task automatic writeBit(input logic b);
    applyStimulus(1'b0, b, Q);
    applyStimulus(1'b1, b, H);
    applyStimulus(1'b0, b, Q);
  endtask

  task automatic readBit(output logic b);
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    #1 b = intf.sda_in;
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b0, 1'b1, Q);
  endtask

  task automatic sendByte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(a);
  endtask

  task automatic recvByte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      d = {d[6:0], b};
    end
    writeBit(nack);
  endtask

  // A byte clocked without START must not be acknowledged.
  task automatic idleProbe(input string name);
    logic a;
    oe_seen = 1'b0;
    sendByte(8'h84, a);
    applyStimulus(1'b1, 1'b1, H);
    checkOutput({name, "_probe_nack"}, 32'(a), 32'd1);
    checkOutput({name, "_probe_no_oe"}, 32'(oe_seen), 32'd0);
  endtask

  task automatic checkQueuesEmpty(input string name);
    waitCycles(4);
    checkOutput({name, "_we_pending"}, 32'(exp_we.size()), 32'd0);
    checkOutput({name, "_re_pending"}, 32'(exp_re.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;

    reset_n = 1'b0;
    waitCycles(3);
    #1;
    checkOutput("rst_sda_oe", 32'(intf.sda_oe), 32'd0);
    checkOutput("rst_reg_addr", 32'(intf.reg_addr), 32'd0);
    checkOutput("rst_reg_wdata", 32'(intf.reg_wdata), 32'd0);
    checkOutput("rst_reg_we", 32'(intf.reg_we), 32'd0);
    checkOutput("rst_reg_re", 32'(intf.reg_re), 32'd0);
    checkOutput("rst_busy", 32'(intf.busy), 32'd0);
    reset_n = 1'b1;
    waitCycles(5);

    $display("[TB] write: 0x84 0x10 0xAB 0xCD");
    exp_we.push_back({8'h10, 8'hAB});
    exp_we.push_back({8'h11, 8'hCD});
    i2cStart();
    checkOutput("wr_busy_high", 32'(intf.busy), 32'd1);
    sendByte(8'h84, ack); checkOutput("wr_ack_addr", 32'(ack), 32'd0);
    sendByte(8'h10, ack); checkOutput("wr_ack_ptr", 32'(ack), 32'd0);
    sendByte(8'hAB, ack); checkOutput("wr_ack_d0", 32'(ack), 32'd0);
    sendByte(8'hCD, ack); checkOutput("wr_ack_d1", 32'(ack), 32'd0);
    i2cStop();
    checkOutput("wr_busy_low", 32'(intf.busy), 32'd0);
    checkOutput("wr_final_addr", 32'(intf.reg_addr), 32'h12);
    checkOutput("wr_mem10", 32'(mem[8'h10]), 32'hAB);
    checkOutput("wr_mem11", 32'(mem[8'h11]), 32'hCD);
    checkQueuesEmpty("wr");

    $display("[TB] read: pointer 0x20, repeated START, two bytes");
    exp_re.push_back(8'h20);
    exp_re.push_back(8'h21);
    i2cStart();
    sendByte(8'h84, ack); checkOutput("rd_ack_waddr", 32'(ack), 32'd0);
    sendByte(8'h20, ack); checkOutput("rd_ack_ptr", 32'(ack), 32'd0);
    i2cStart();
    sendByte(8'h85, ack); checkOutput("rd_ack_raddr", 32'(ack), 32'd0);
    recvByte(rx, 1'b0); checkOutput("rd_byte0", 32'(rx), 32'h5A);
    recvByte(rx, 1'b1); checkOutput("rd_byte1", 32'(rx), 32'hC3);
    waitCycles(4);
    checkOutput("rd_oe_after_nack", 32'(intf.sda_oe), 32'd0);
    i2cStop();
    checkOutput("rd_busy_low", 32'(intf.busy), 32'd0);
    checkQueuesEmpty("rd");

    $display("[TB] address mismatch: 0x86 0x55");
    oe_seen = 1'b0;
    i2cStart();
    sendByte(8'h86, ack); checkOutput("mm_nack_addr", 32'(ack), 32'd1);
    sendByte(8'h55, ack); checkOutput("mm_nack_data", 32'(ack), 32'd1);
    i2cStop();
    checkOutput("mm_no_oe", 32'(oe_seen), 32'd0);
    checkOutput("mm_busy_low", 32'(intf.busy), 32'd0);
    checkQueuesEmpty("mm");
    idleProbe("mm");

    $display("[TB] pointer wrap and STOP abort");
    exp_we.push_back({8'hFF, 8'h11});
    exp_we.push_back({8'h00, 8'h22});
    i2cStart();
    sendByte(8'h84, ack); checkOutput("wp_ack_addr", 32'(ack), 32'd0);
    sendByte(8'hFF, ack); checkOutput("wp_ack_ptr", 32'(ack), 32'd0);
    sendByte(8'h11, ack); checkOutput("wp_ack_d0", 32'(ack), 32'd0);
    sendByte(8'h22, ack); checkOutput("wp_ack_d1", 32'(ack), 32'd0);
    writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b1);
    i2cStop();
    checkOutput("wp_busy_low", 32'(intf.busy), 32'd0);
    checkOutput("wp_final_addr", 32'(intf.reg_addr), 32'h01);
    checkOutput("wp_memFF", 32'(mem[8'hFF]), 32'h11);
    checkOutput("wp_mem00", 32'(mem[8'h00]), 32'h22);
    checkQueuesEmpty("wp");
    idleProbe("wp");

    $display("[TB] asynchronous reset while ACK is driven");
    i2cStart();
    for (int i = 7; i >= 0; i--) writeBit(1'(8'h84 >> i));
    applyStimulus(1'b0, 1'b1, Q);
    #1;
    checkOutput("ar_oe_before", 32'(intf.sda_oe), 32'd1);
    checkOutput("ar_busy_before", 32'(intf.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("ar_oe_async", 32'(intf.sda_oe), 32'd0);
    checkOutput("ar_busy_async", 32'(intf.busy), 32'd0);
    applyStimulus(1'b1, 1'b1, H);
    reset_n = 1'b1;
    waitCycles(10);
    checkOutput("ar_busy_after", 32'(intf.busy), 32'd0);
    checkQueuesEmpty("ar");
    idleProbe("ar");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
